// File: rtl/tone_gen.sv
// Speaker tone generator: turns an accepted note preset into a glitch-free 50%-duty square wave,
// with rest, mute and a short articulation gap after each beat.
module tone_gen #(
    parameter int unsigned CNT_W     = 11,
    parameter int unsigned REST_CODE = 2047,
    parameter int unsigned GAP_CYC   = 2000,
    parameter int unsigned GAP_W     = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] tn,
    input  logic             beat,
    input  logic             mute,
    output logic             spk,
    output logic             sounding,
    output logic             note_chg
);

    localparam logic [CNT_W-1:0] REST     = CNT_W'(REST_CODE);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam bit               GAP_EN   = (GAP_CYC > 0);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_EN ? GAP_W'(GAP_CYC - 1) : '0;

    typedef enum logic [1:0] {StIdle, StTone, StGap} state_t;

    state_t           state;
    logic [CNT_W-1:0] tn_s1, tn_s2, tn_acc;
    logic [CNT_W-1:0] cnt, per;
    logic [GAP_W-1:0] gap;

    // tn comes from the slow beat domain; accept it only once two samples agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tn_s1    <= REST;
            tn_s2    <= REST;
            tn_acc   <= REST;
            note_chg <= 1'b0;
        end else begin
            tn_s1    <= tn;
            tn_s2    <= tn_s1;
            note_chg <= 1'b0;
            if (tn_s1 == tn_s2 && tn_s2 != tn_acc) begin
                tn_acc   <= tn_s2;
                note_chg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            cnt      <= REST;
            per      <= REST;
            gap      <= '0;
            spk      <= 1'b0;
            sounding <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    spk <= 1'b0;
                    if (!mute && tn_acc != REST) begin
                        state    <= StTone;
                        sounding <= 1'b1;
                        per      <= tn_acc;
                        cnt      <= tn_acc;
                    end
                end
                StTone: begin
                    if (mute) begin
                        state    <= StIdle;
                        sounding <= 1'b0;
                        spk      <= 1'b0;
                    end else if (GAP_EN && beat) begin
                        state    <= StGap;
                        sounding <= 1'b0;
                        spk      <= 1'b0;
                        gap      <= GAP_LOAD;
                    end else if (cnt == CNT_MAX) begin
                        // Period boundary: the only place a new note is allowed to take effect.
                        cnt <= per;
                        per <= tn_acc;
                        if (tn_acc == REST) begin
                            state    <= StIdle;
                            sounding <= 1'b0;
                            spk      <= 1'b0;
                        end else begin
                            spk <= ~spk;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StGap: begin
                    spk <= 1'b0;
                    if (beat) begin
                        gap <= GAP_LOAD;
                    end else if (gap == '0) begin
                        if (mute || tn_acc == REST) begin
                            state <= StIdle;
                        end else begin
                            state    <= StTone;
                            sounding <= 1'b1;
                            per      <= tn_acc;
                            cnt      <= tn_acc;
                        end
                    end else begin
                        gap <= gap - 1'b1;
                    end
                end
                default: begin
                    state    <= StIdle;
                    sounding <= 1'b0;
                    spk      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen: period timing, note changes, rest, beat gap, mute, tn glitch
// filtering and asynchronous reset.
module tb_tone_gen;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] tn    = 11'd2047;
    logic        beat  = 1'b0;
    logic        mute  = 1'b0;
    logic        spk, sounding, note_chg;

    int checks  = 0;
    int fails   = 0;
    int chg_cnt = 0;
    int n, snap, hits;

    tone_gen #(
        .CNT_W    (11),
        .REST_CODE(2047),
        .GAP_CYC  (8),
        .GAP_W    (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tn      (tn),
        .beat    (beat),
        .mute    (mute),
        .spk     (spk),
        .sounding(sounding),
        .note_chg(note_chg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (note_chg === 1'b1) chg_cnt++;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges until spk changes; -1 if it never does within the bound.
    task automatic wait_toggle(output int cyc);
        logic prev;
        prev = spk;
        cyc  = -1;
        for (int i = 1; i <= 5000; i++) begin
            step();
            if (spk !== prev) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic wait_sounding(input logic lvl, output int cyc);
        cyc = -1;
        for (int i = 1; i <= 5000; i++) begin
            step();
            if (sounding === lvl) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        check("rst_spk", int'(spk), 0);
        check("rst_sounding", int'(sounding), 0);
        check("rst_note_chg", int'(note_chg), 0);

        // 1: steady note 1036 -> half-period 2048-1036 = 1012
        snap  = chg_cnt;
        tn    = 11'd1036;
        rst_n = 1'b1;
        wait_sounding(1'b1, n);
        check("t1_sound_latency", n, 4);
        wait_toggle(n);
        check("t1_first_half", n, 1012);
        check("t1_spk_high", int'(spk), 1);
        wait_toggle(n);
        check("t1_half2", n, 1012);
        wait_toggle(n);
        check("t1_half3", n, 1012);
        check("t1_note_chg_pulses", chg_cnt - snap, 1);

        // 2: change to 1290 mid half-period -> current half still 1012, then 758
        snap = chg_cnt;
        repeat (300) step();
        tn = 11'd1290;
        wait_toggle(n);
        check("t2_current_half", 300 + n, 1012);
        wait_toggle(n);
        wait_toggle(n);
        check("t2_new_half_a", n, 758);
        wait_toggle(n);
        check("t2_new_half_b", n, 758);
        check("t2_note_chg_pulses", chg_cnt - snap, 1);

        // 3: rest code while sounding -> silent at the next wrap, nothing afterwards
        tn = 11'd2047;
        wait_sounding(1'b0, n);
        check("t3_rest_at_wrap", n, 758);
        check("t3_spk_low", int'(spk), 0);
        hits = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (spk !== 1'b0 || sounding !== 1'b0) hits++;
        end
        check("t3_stays_silent", hits, 0);

        // 4: beat in TONE -> 8 cycles of gap, then restart with full first half-period
        tn = 11'd1036;
        wait_sounding(1'b1, n);
        check("t4_restart_latency", n, 4);
        wait_toggle(n);
        check("t4_first_half", n, 1012);
        repeat (100) step();
        beat = 1'b1;
        step();
        beat = 1'b0;
        check("t4_gap_spk", int'(spk), 0);
        check("t4_gap_sounding", int'(sounding), 0);
        hits = 0;
        n    = -1;
        for (int i = 1; i <= 50; i++) begin
            step();
            if (spk !== 1'b0) hits++;
            if (sounding === 1'b1) begin
                n = i;
                break;
            end
        end
        check("t4_gap_len", n, 8);
        check("t4_gap_silent", hits, 0);
        wait_toggle(n);
        check("t4_after_gap_half", n, 1012);

        // 5: mute mid half-period -> silent on the next edge, unmute restarts
        repeat (200) step();
        mute = 1'b1;
        step();
        check("t5_mute_spk", int'(spk), 0);
        check("t5_mute_sounding", int'(sounding), 0);
        repeat (50) step();
        check("t5_muted_spk", int'(spk), 0);
        mute = 1'b0;
        wait_sounding(1'b1, n);
        check("t5_unmute_latency", n, 1);
        wait_toggle(n);
        check("t5_unmute_half", n, 1012);

        // 6: single-cycle glitch on tn is dropped
        snap = chg_cnt;
        repeat (100) step();
        tn = 11'd500;
        step();
        tn = 11'd1036;
        wait_toggle(n);
        check("t6_glitch_half", 101 + n, 1012);
        wait_toggle(n);
        check("t6_glitch_next_half", n, 1012);
        check("t6_no_note_chg", chg_cnt - snap, 0);

        // Asynchronous reset mid-tone
        repeat (100) step();
        check("t6_pre_rst_spk", int'(spk), 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_spk", int'(spk), 0);
        check("t6_rst_sounding", int'(sounding), 0);
        check("t6_rst_note_chg", int'(note_chg), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
